// File: rtl/shift_pkg.sv
// shift_pkg: opcodes and FSM state encodings for the multi-mode shift register
package shift_pkg;
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SAR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational 1-bit shift/rotate step and the bit it pushes out
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             left_in,
  input  logic             right_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);
  // left ops exit via the MSB, right ops via the LSB; unknown ops hold q
  always_comb begin
    next_q  = op == OP_SHL ? {q[WIDTH-2:0], right_in} :
              op == OP_SHR ? {left_in, q[WIDTH-1:1]} :
              op == OP_SAR ? {q[WIDTH-1], q[WIDTH-1:1]} :
              op == OP_ROL ? {q[WIDTH-2:0], q[WIDTH-1]} :
              op == OP_ROR ? {q[0], q[WIDTH-1:1]} : q;
    out_bit = (op == OP_SHL || op == OP_ROL) ? q[WIDTH-1] :
              (op == OP_SHR || op == OP_SAR || op == OP_ROR) ? q[0] : 1'b0;
  end
endmodule

// File: rtl/shift_reg_multi.sv
// shift_reg_multi: load/shift/rotate register, one bit per clock, start/busy/done handshake
module shift_reg_multi import shift_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             left_in,
  input  logic             right_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);
  state_t           state, state_n;
  logic [AMT_W-1:0] count, count_n;
  logic [2:0]       op_r, op_n;
  logic [WIDTH-1:0] q_n, step_q;
  logic             c_n, step_bit, done_n;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q(q), .op(op_r), .left_in(left_in), .right_in(right_in),
    .next_q(step_q), .out_bit(step_bit)
  );

  assign busy = state == ST_SHIFT;

  // state and datapath registers; reset is asynchronous and active-low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      op_r      <= OP_LOAD;
      q         <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      op_r      <= op_n;
      q         <= q_n;
      carry_out <= c_n;
      done      <= done_n;
    end
  end

  // next-state: immediate completion for LOAD/NOP/zero count, else count down one step per edge
  always_comb begin
    state_n = state;
    count_n = count;
    op_n    = op_r;
    q_n     = q;
    c_n     = carry_out;
    done_n  = 1'b0;
    if (state == ST_IDLE) begin
      if (start) begin
        if (op == OP_LOAD) begin
          q_n    = d;
          c_n    = 1'b0;
          done_n = 1'b1;
        end else if (op[2:1] == 2'b11 || amt == '0) begin
          done_n = 1'b1;
        end else begin
          op_n    = op;
          count_n = amt;
          state_n = ST_SHIFT;
        end
      end
    end else if (abort) begin
      count_n = '0;
      state_n = ST_IDLE;
    end else begin
      q_n     = step_q;
      c_n     = step_bit;
      count_n = count - 1'b1;
      if (count == 1) begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_shift_reg_multi.sv
// tb_shift_reg_multi: directed scoreboard bench for shift_reg_multi at WIDTH=8
module tb_shift_reg_multi;
  logic       clk = 0, rst = 0, start = 0, abort = 0, left_in = 0, right_in = 0;
  logic [2:0] op = 0;
  logic [3:0] amt = 0;
  logic [7:0] d = 0, q;
  logic       carry_out, busy, done;
  int         checks = 0, errors = 0;
  logic [7:0] mq = 0;
  logic       mc = 0;

  typedef struct packed {logic [7:0] q; logic c; int lat; int nb;} exp_t;
  exp_t sb[$];

  shift_reg_multi #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .amt(amt),
    .d(d), .left_in(left_in), .right_in(right_in), .q(q),
    .carry_out(carry_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // independent reference: apply one step to the bench's model of q/carry
  task automatic model_step(input logic [2:0] o);
    logic [7:0] t;
    t = mq;
    case (o)
      3'd1: begin mc = t[7]; mq = (t << 1) | {7'b0, right_in}; end
      3'd2: begin mc = t[0]; mq = (t >> 1) | {left_in, 7'b0}; end
      3'd3: begin mc = t[0]; mq = {t[7], t[7:1]}; end
      3'd4: begin mc = t[7]; mq = {t[6:0], t[7]}; end
      3'd5: begin mc = t[0]; mq = {t[0], t[7:1]}; end
      default: ;
    endcase
  endtask

  // drive one start, predict result into the scoreboard, wait for done and compare
  task automatic do_op(input string tag, input logic [2:0] o, input logic [3:0] a, input logic [7:0] dv);
    exp_t e;
    int n, nb;
    bit got;
    if (o == 3'd0) begin
      mq = dv;
      mc = 1'b0;
      e.lat = 1;
      e.nb = 0;
    end else if (o[2:1] == 2'b11 || a == 0) begin
      e.lat = 1;
      e.nb = 0;
    end else begin
      for (int i = 0; i < a; i++) model_step(o);
      e.lat = a + 1;
      e.nb = a;
    end
    e.q = mq;
    e.c = mc;
    sb.push_back(e);
    start = 1; op = o; amt = a; d = dv;
    n = 0; nb = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      start = 0;
      n++;
      if (busy) nb++;
      if (done) got = 1;
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, {31'b0, got}, 1);
    check({tag, "_q"}, {24'b0, q}, {24'b0, e.q});
    check({tag, "_carry"}, {31'b0, carry_out}, {31'b0, e.c});
    check({tag, "_latency"}, n, e.lat);
    check({tag, "_busy_cycles"}, nb, e.nb);
  endtask

  initial begin
    int dn;
    // 1. reset
    repeat (3) tick();
    check("rst_q", {24'b0, q}, 0);
    check("rst_carry", {31'b0, carry_out}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rst = 1;
    tick();
    check("post_rst_q", {24'b0, q}, 0);
    // 2. load
    do_op("load_a5", 3'd0, 4'd0, 8'hA5);
    tick();
    check("load_done_one_cycle", {31'b0, done}, 0);
    // 3. arithmetic shift
    do_op("sar3", 3'd3, 4'd3, 8'h00);
    check("sar3_const_q", {24'b0, q}, 32'hF4);
    tick();
    check("sar3_done_one_cycle", {31'b0, done}, 0);
    // 4. rotate past width
    do_op("load_81", 3'd0, 4'd0, 8'h81);
    do_op("rol9", 3'd4, 4'd9, 8'h00);
    check("rol9_const_q", {24'b0, q}, 32'h03);
    // 5. zero count and NOP complete at once, back-to-back
    do_op("shl0", 3'd1, 4'd0, 8'hFF);
    do_op("nop", 3'd6, 4'd4, 8'hFF);
    do_op("nop7", 3'd7, 4'd2, 8'hFF);
    // long shifts with fills, rotate right
    right_in = 1;
    do_op("load_0f", 3'd0, 4'd0, 8'h0F);
    do_op("shl10_fill1", 3'd1, 4'd10, 8'h00);
    right_in = 0;
    left_in = 0;
    do_op("shr8_fill0", 3'd2, 4'd8, 8'h00);
    do_op("load_96", 3'd0, 4'd0, 8'h96);
    do_op("ror3", 3'd5, 4'd3, 8'h00);
    do_op("sar8", 3'd3, 4'd8, 8'h00);
    left_in = 1;
    do_op("load_02", 3'd0, 4'd0, 8'h02);
    do_op("shr2_fill1", 3'd2, 4'd2, 8'h00);
    tick();
    // 6. start ignored while busy, then abort after two shifts
    left_in = 0;
    do_op("load_f0", 3'd0, 4'd0, 8'hF0);
    start = 1; op = 3'd2; amt = 4'd5;
    tick();
    start = 1; op = 3'd0; d = 8'h55; amt = 4'd1;
    tick();
    start = 0;
    check("abort_ignored_start_q", {24'b0, q}, 32'h78);
    check("abort_busy_mid", {31'b0, busy}, 1);
    tick();
    check("abort_two_shifts_q", {24'b0, q}, 32'h3C);
    abort = 1;
    tick();
    abort = 0;
    check("abort_q", {24'b0, q}, 32'h3C);
    check("abort_carry", {31'b0, carry_out}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    dn = done;
    for (int i = 0; i < 8; i++) begin tick(); dn += done; end
    check("abort_no_done", dn, 0);
    check("abort_q_held", {24'b0, q}, 32'h3C);
    // 1b. reset in the middle of a shift
    do_op("load_ff", 3'd0, 4'd0, 8'hFF);
    start = 1; op = 3'd1; amt = 4'd6;
    tick();
    start = 0;
    tick();
    tick();
    rst = 0;
    #1;
    check("midrst_q", {24'b0, q}, 0);
    check("midrst_carry", {31'b0, carry_out}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    #3 rst = 1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin tick(); dn += done + busy; end
    check("midrst_no_resume", dn, 0);
    check("midrst_q_after", {24'b0, q}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
